div_sequencer: RTL and testbench

- Hardware sequencer for the fixed-point divide operation: 16-bit dividend / 8-bit divisor -> 24-bit quotient (16 integer + 8 fraction bits, truncated).
- Sits beside the CPU on the data-memory port. On Start it fetches operands from data memory, runs a 24-step restoring shift-subtract datapath, writes the result back and raises Ack.
- While Busy is high, the CPU is stalled and the sequencer owns the memory port.

---
 rtl/div_sequencer.sv | 156 +++++++++++++++
 tb/tb_div_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// Memory-mapped fixed-point divide sequencer: fetches a 16-bit dividend and 8-bit divisor,
// runs a 24-step restoring divide and writes the 24-bit (16.8) quotient back to memory.
module div_sequencer #(
    parameter int AW       = 8,
    parameter int IN_BASE  = 0,
    parameter int OUT_BASE = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    output logic          Ack,
    output logic          Busy,
    output logic [AW-1:0] MemAddr,
    output logic          MemWrEn,
    output logic [7:0]    MemWrData,
    input  logic [7:0]    MemRdData
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_RD_HI  = 4'd1;
    localparam logic [3:0] S_RD_LO  = 4'd2;
    localparam logic [3:0] S_RD_DIV = 4'd3;
    localparam logic [3:0] S_CAP    = 4'd4;
    localparam logic [3:0] S_DIV    = 4'd5;
    localparam logic [3:0] S_WR_HI  = 4'd6;
    localparam logic [3:0] S_WR_MID = 4'd7;
    localparam logic [3:0] S_WR_LO  = 4'd8;
    localparam logic [3:0] S_DONE   = 4'd9;

    localparam logic [AW-1:0] ADDR_IN_HI   = AW'(IN_BASE);
    localparam logic [AW-1:0] ADDR_IN_LO   = AW'(IN_BASE + 1);
    localparam logic [AW-1:0] ADDR_IN_DIV  = AW'(IN_BASE + 2);
    localparam logic [AW-1:0] ADDR_OUT_HI  = AW'(OUT_BASE);
    localparam logic [AW-1:0] ADDR_OUT_MID = AW'(OUT_BASE + 1);
    localparam logic [AW-1:0] ADDR_OUT_LO  = AW'(OUT_BASE + 2);

    logic [3:0]  state_q,    state_d;
    logic [15:0] dividend_q, dividend_d;
    logic [7:0]  divisor_q,  divisor_d;
    logic [23:0] num_q,      num_d;
    logic [7:0]  rem_q,      rem_d;
    logic [23:0] quot_q,     quot_d;
    logic [4:0]  count_q,    count_d;
    logic [8:0]  trial;

    // The partial remainder is always below the divisor, so 8 bits hold it; the
    // shifted-in trial value needs the ninth bit.
    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        num_d      = num_q;
        rem_d      = rem_q;
        quot_d     = quot_q;
        count_d    = count_q;
        trial      = {rem_q, num_q[count_q]};

        case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_RD_HI;
            end
            S_RD_HI: state_d = S_RD_LO;
            S_RD_LO: begin
                dividend_d[15:8] = MemRdData;
                state_d          = S_RD_DIV;
            end
            S_RD_DIV: begin
                dividend_d[7:0] = MemRdData;
                state_d         = S_CAP;
            end
            S_CAP: begin
                divisor_d = MemRdData;
                num_d     = {dividend_q, 8'h00};
                rem_d     = 8'h00;
                count_d   = 5'd23;
                if (MemRdData == 8'h00) begin
                    quot_d  = 24'hFFFFFF;
                    state_d = S_WR_HI;
                end else begin
                    quot_d  = 24'h000000;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                if (trial >= {1'b0, divisor_q}) begin
                    rem_d           = 8'(trial - {1'b0, divisor_q});
                    quot_d[count_q] = 1'b1;
                end else begin
                    rem_d           = trial[7:0];
                    quot_d[count_q] = 1'b0;
                end
                if (count_q == 5'd0) state_d = S_WR_HI;
                else                 count_d = count_q - 5'd1;
            end
            S_WR_HI:  state_d = S_WR_MID;
            S_WR_MID: state_d = S_WR_LO;
            S_WR_LO:  state_d = S_DONE;
            S_DONE: begin
                if (Start) state_d = S_RD_HI;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            dividend_q <= 16'h0000;
            divisor_q  <= 8'h00;
            num_q      <= 24'h000000;
            rem_q      <= 8'h00;
            quot_q     <= 24'h000000;
            count_q    <= 5'd0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            num_q      <= num_d;
            rem_q      <= rem_d;
            quot_q     <= quot_d;
            count_q    <= count_d;
        end
    end

    // Outputs decode straight from the state register; the write strobe is also
    // gated by Reset so an abort never lands a stray byte in memory.
    always_comb begin
        Ack       = (state_q == S_DONE);
        Busy      = (state_q >= S_RD_HI) && (state_q <= S_WR_LO);
        MemAddr   = '0;
        MemWrEn   = 1'b0;
        MemWrData = 8'h00;
        case (state_q)
            S_RD_HI:  MemAddr = ADDR_IN_HI;
            S_RD_LO:  MemAddr = ADDR_IN_LO;
            S_RD_DIV: MemAddr = ADDR_IN_DIV;
            S_WR_HI: begin
                MemAddr   = ADDR_OUT_HI;
                MemWrEn   = ~Reset;
                MemWrData = quot_q[23:16];
            end
            S_WR_MID: begin
                MemAddr   = ADDR_OUT_MID;
                MemWrEn   = ~Reset;
                MemWrData = quot_q[15:8];
            end
            S_WR_LO: begin
                MemAddr   = ADDR_OUT_LO;
                MemWrEn   = ~Reset;
                MemWrData = quot_q[7:0];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus randomized operands
// compared against floor(dividend*256/divisor) from a plain arithmetic reference.
module tb_div_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       ack;
    logic       busy;
    logic [7:0] memAddr;
    logic       memWrEn;
    logic [7:0] memWrData;
    logic [7:0] memRdData;

    logic [7:0] mem [0:255];
    int checks  = 0;
    int errors  = 0;
    int wrCount = 0;

    always #5 clk = ~clk;

    div_sequencer #(.AW(8), .IN_BASE(0), .OUT_BASE(4)) dut (
        .Clk(clk), .Reset(reset), .Start(start), .Ack(ack), .Busy(busy),
        .MemAddr(memAddr), .MemWrEn(memWrEn), .MemWrData(memWrData), .MemRdData(memRdData)
    );

    // Registered data memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        memRdData <= mem[memAddr];
        if (memWrEn) begin
            mem[memAddr] <= memWrData;
            wrCount      <= wrCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] refQuotient(input int unsigned a, input int unsigned b);
        if (b == 0) return 24'hFFFFFF;
        return 24'((a * 256) / b);
    endfunction

    function automatic logic [23:0] resultBytes();
        return {mem[4], mem[5], mem[6]};
    endfunction

    // One complete operation launched by a single-cycle Start pulse; optional
    // Start re-pulse and operand scrambling while the divide is in flight.
    task automatic applyStimulus(input logic [15:0] dividend, input logic [7:0] divisor,
                                 input int repulseAt, input bit scramble);
        logic [23:0] expQ;
        int expLat;
        int cycles;
        int busyCycles;
        int w0;
        expQ   = refQuotient(dividend, divisor);
        expLat = (divisor == 8'h00) ? 8 : 32;
        mem[0] = dividend[15:8];
        mem[1] = dividend[7:0];
        mem[2] = divisor;
        mem[4] = ~expQ[23:16];
        mem[5] = ~expQ[15:8];
        mem[6] = ~expQ[7:0];
        busyCycles = 0;
        @(negedge clk);
        w0    = wrCount;
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (!ack && cycles < 100) begin
            if (busy) busyCycles++;
            start = (cycles == repulseAt);
            if (scramble && cycles == 10) begin
                mem[0] = 8'($urandom);
                mem[1] = 8'($urandom);
                mem[2] = 8'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput("ackLatency", cycles, expLat);
        checkOutput("busyCycles", busyCycles, expLat - 1);
        checkOutput("busyInDone", {31'd0, busy}, 32'd0);
        checkOutput("writeStrobes", wrCount - w0, 3);
        checkOutput("quotient", {8'd0, resultBytes()}, {8'd0, expQ});
    endtask

    initial begin
        int cycles;
        int w0;
        logic [15:0] a;
        logic [7:0]  b;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("resetAck", {31'd0, ack}, 0);
        checkOutput("resetBusy", {31'd0, busy}, 0);
        checkOutput("resetWrEn", {31'd0, memWrEn}, 0);
        checkOutput("resetAddr", {24'd0, memAddr}, 0);
        checkOutput("resetWrData", {24'd0, memWrData}, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idleAck", {31'd0, ack}, 0);

        applyStimulus(16'd385, 8'd6, 0, 1'b0);
        checkOutput("directed385", {8'd0, resultBytes()}, 32'h00402A);
        applyStimulus(16'd65535, 8'd1, 0, 1'b0);
        checkOutput("directedMax", {8'd0, resultBytes()}, 32'hFFFF00);
        applyStimulus(16'd3, 8'd255, 0, 1'b0);
        checkOutput("directed3by255", {8'd0, resultBytes()}, 32'h000003);
        applyStimulus(16'd1, 8'd255, 0, 1'b0);
        checkOutput("directed1by255", {8'd0, resultBytes()}, 32'h000001);
        applyStimulus(16'd1234, 8'd0, 0, 1'b0);
        checkOutput("divByZero", {8'd0, resultBytes()}, 32'hFFFFFF);

        // Reset during the divide: no writes, outputs idle, then a clean rerun.
        mem[0] = 8'h01; mem[1] = 8'h81; mem[2] = 8'd6;
        mem[4] = 8'hAA; mem[5] = 8'hAA; mem[6] = 8'hAA;
        @(negedge clk);
        w0    = wrCount;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abortAck", {31'd0, ack}, 0);
        checkOutput("abortBusy", {31'd0, busy}, 0);
        repeat (40) @(negedge clk);
        checkOutput("abortWrites", wrCount - w0, 0);
        checkOutput("abortMem", {8'd0, resultBytes()}, 32'hAAAAAA);
        applyStimulus(16'd385, 8'd6, 0, 1'b0);

        // Start re-pulsed mid-divide and operands changed after capture.
        applyStimulus(16'd385, 8'd6, 12, 1'b1);
        applyStimulus(16'd50000, 8'd7, 20, 1'b1);

        // Start held high: back-to-back runs, one cycle in DONE each.
        mem[0] = 8'h01; mem[1] = 8'h81; mem[2] = 8'd6;
        mem[4] = 8'h00; mem[5] = 8'h00; mem[6] = 8'h00;
        @(negedge clk);
        w0    = wrCount;
        start = 1'b1;
        @(negedge clk);
        cycles = 1;
        while (!ack && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("heldFirstLatency", cycles, 32);
        @(negedge clk);
        checkOutput("heldAckDrops", {31'd0, ack}, 0);
        checkOutput("heldRestartBusy", {31'd0, busy}, 1);
        cycles = 1;
        while (!ack && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput("heldSecondLatency", cycles, 32);
        checkOutput("heldWrites", wrCount - w0, 6);
        checkOutput("heldResult", {8'd0, resultBytes()}, 32'h00402A);

        for (int n = 0; n < 500; n++) begin
            a = 16'($urandom);
            b = 8'($urandom_range(0, 255));
            applyStimulus(a, b, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
